flop_share_ctrl: RTL and testbench
==================================

Name: flop_share_ctrl

Overview:
Sequencer and round-robin arbiter that shares the single 8-bit reset-able register (clk, reset, qin -> qout) between N_REQ requesters. It owns the register's reset and qin inputs and keeps the stored value stable between writes by re-driving it. Each write is verified by reading back qout. It also performs a multi-cycle clear of the register on power-up and on request.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, data width of the shared register
CLR_CYCLES, 3, cycles flop_reset is held during a clear (>=1)

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  asynchronous, active-low controller reset
req  in  N_REQ  per-requester write request, level
wdata  in  N_REQ*WIDTH  per-requester write data; slice i = wdata[i*WIDTH +: WIDTH]
gnt  out  N_REQ  one-hot grant, one-cycle pulse
done  out  1  one-cycle pulse: granted write completed and read back
err  out  1  sticky readback-mismatch flag
err_id  out  $clog2(N_REQ)  requester index of the first mismatch
clr_req  in  1  request a register clear, level
clr_busy  out  1  high while a clear sequence runs
flop_reset  out  1  active-high reset to the shared register
flop_qin  out  WIDTH  data to the shared register
flop_qout  in  WIDTH  shared register output

Behaviour:
- All outputs are registered. FSM states are CLEAR, IDLE, WRITE, CHECK.
- While reset=0, the block asynchronously forces:
  - state=CLEAR with the clear counter at CLR_CYCLES-1
  - flop_reset=1, clr_busy=1, flop_qin=0
  - gnt=0, done=0, err=0, err_id=0
  - round-robin pointer=0, held value=0
- CLEAR:
  - flop_reset=1, clr_busy=1, flop_qin=0.
  - The counter decrements each cycle. When it reaches 0: flop_reset=0, clr_busy=0, held value=0, next state IDLE.
  - flop_reset is therefore high for exactly CLR_CYCLES cycles after reset release.
- IDLE:
  - flop_qin = held value, so the register retains its contents.
  - clr_req=1 has priority over req. It reloads the counter to CLR_CYCLES-1 and enters CLEAR.
  - Otherwise, if any req bit is set, pick winner i: the first set bit at or after the pointer, wrapping from N_REQ-1 to 0.
  - At that edge: gnt[i]=1, flop_qin=wdata slice i, held value=wdata slice i, latched id=i, pointer=(i+1) mod N_REQ, next state WRITE.
  - req and wdata are sampled only at this edge.
- WRITE (one cycle):
  - gnt is a one-cycle pulse; it returns to 0 at the exit edge.
  - The register captures flop_qin at the exit edge. Next state CHECK.
- CHECK (one cycle):
  - Compare flop_qout against the held value.
  - At the exit edge: done=1 for one cycle.
  - On mismatch with err=0: err=1 and err_id=latched id. Later mismatches do not change err_id.
  - Next state IDLE.
- Latency: req sampled at edge T -> gnt high during T..T+1 -> flop_qout valid after T+1 -> done high during T+2..T+3.
- Throughput: one write per 3 cycles. A requester that keeps req high is re-arbitrated in turn.
- A requester deasserts req after seeing its gnt if it has no further writes.
- req and clr_req are ignored outside IDLE. A request still asserted on return to IDLE is served then.
- err is cleared only by reset, not by a clear sequence.
- Reset asserted mid-WRITE or mid-CHECK aborts immediately. done is not issued for the aborted write, and the power-up clear restarts.

Test Plan:
- Reset release -> flop_reset=1 and clr_busy=1 for exactly 3 cycles, then 0; flop_qin=8'h00; flop_qout=8'h00; gnt=0.
- req=4'b0100, wdata slice 2=8'hA5 at edge T:
  - gnt=4'b0100 for T..T+1; flop_qout=8'hA5 after T+1
  - done pulse T+2..T+3; err=0
  - flop_qout still 8'hA5 ten cycles later
- req=4'b1111 held, slices 8'h10/8'h11/8'h12/8'h13:
  - grants in order 0,1,2,3,0, spaced 3 cycles apart
  - flop_qout follows 10,11,12,13,10
- clr_req=1 and req=4'b0010 in the same IDLE cycle:
  - clear first: flop_reset high 3 cycles, flop_qout=8'h00
  - then gnt=4'b0010 and the write of slice 1 completes
- Write 8'h3C from requester 3 while the bench forces flop_qout=8'h00 during CHECK:
  - done pulses, err=1, err_id=3
  - a subsequent good write leaves err=1, err_id=3
- reset low for 1 cycle during WRITE of 8'hFF:
  - gnt drops to 0 immediately; no done pulse
  - clr_busy=1 and flop_reset=1 for 3 cycles after release; flop_qout=8'h00 after the clear

Source files
------------

// File: rtl/flop_share_ctrl.sv
// flop_share_ctrl: round-robin sequencer that owns one shared reset-able
// register. Writes are granted one at a time, held by re-driving qin, and
// verified by reading qout back one cycle after the register captures.
module flop_share_ctrl #(
  parameter  int N_REQ      = 4,
  parameter  int WIDTH      = 8,
  parameter  int CLR_CYCLES = 3,
  localparam int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic                   done,
  output logic                   err,
  output logic [IDW-1:0]         err_id,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic                   flop_reset,
  output logic [WIDTH-1:0]       flop_qin,
  input  logic [WIDTH-1:0]       flop_qout
);

  localparam int            CW       = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_INIT = CW'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WRITE, S_CHECK} state_t;

  state_t            r_state,  w_state_nx;
  logic [CW-1:0]     r_cnt,    w_cnt_nx;
  logic [IDW-1:0]    r_ptr,    w_ptr_nx;
  logic [IDW-1:0]    r_id,     w_id_nx;
  logic [WIDTH-1:0]  r_held,   w_held_nx;
  logic [N_REQ-1:0]  r_gnt,    w_gnt_nx;
  logic              r_done,   w_done_nx;
  logic              r_err,    w_err_nx;
  logic [IDW-1:0]    r_err_id, w_err_id_nx;
  logic              r_busy,   w_busy_nx;
  logic              r_frst,   w_frst_nx;
  logic [WIDTH-1:0]  r_qin,    w_qin_nx;

  logic [WIDTH-1:0]  w_slice [N_REQ];
  logic [IDW-1:0]    w_win;
  logic [IDW-1:0]    w_idx;
  logic              w_any;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign w_slice[i] = wdata[i*WIDTH +: WIDTH];
  end

  // Round-robin pick: scanning offsets high-to-low leaves the first set bit
  // at or after the pointer as the final winner.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = IDW'((int'(r_ptr) + k) % N_REQ);
      if (req[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_ptr_nx    = r_ptr;
    w_id_nx     = r_id;
    w_held_nx   = r_held;
    w_gnt_nx    = '0;
    w_done_nx   = 1'b0;
    w_err_nx    = r_err;
    w_err_id_nx = r_err_id;
    w_busy_nx   = r_busy;
    w_frst_nx   = r_frst;
    w_qin_nx    = r_qin;
    unique case (r_state)
      S_CLEAR: begin
        w_frst_nx = 1'b1;
        w_busy_nx = 1'b1;
        w_qin_nx  = '0;
        if (r_cnt == '0) begin
          w_frst_nx  = 1'b0;
          w_busy_nx  = 1'b0;
          w_held_nx  = '0;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      S_IDLE: begin
        w_qin_nx = r_held;
        if (clr_req) begin
          w_cnt_nx   = CLR_INIT;
          w_frst_nx  = 1'b1;
          w_busy_nx  = 1'b1;
          w_qin_nx   = '0;
          w_state_nx = S_CLEAR;
        end else if (w_any) begin
          w_gnt_nx[w_win] = 1'b1;
          w_qin_nx   = w_slice[w_win];
          w_held_nx  = w_slice[w_win];
          w_id_nx    = w_win;
          w_ptr_nx   = (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
          w_state_nx = S_WRITE;
        end
      end
      // Register captures flop_qin at this state's exit edge.
      S_WRITE: w_state_nx = S_CHECK;
      S_CHECK: begin
        w_done_nx = 1'b1;
        if (flop_qout != r_held && !r_err) begin
          w_err_nx    = 1'b1;
          w_err_id_nx = r_id;
        end
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_CLEAR;
    endcase
  end

  // State and output registers; reset restarts the power-up clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_CLEAR;
      r_cnt    <= CLR_INIT;
      r_ptr    <= '0;
      r_id     <= '0;
      r_held   <= '0;
      r_gnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_err_id <= '0;
      r_busy   <= 1'b1;
      r_frst   <= 1'b1;
      r_qin    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_ptr    <= w_ptr_nx;
      r_id     <= w_id_nx;
      r_held   <= w_held_nx;
      r_gnt    <= w_gnt_nx;
      r_done   <= w_done_nx;
      r_err    <= w_err_nx;
      r_err_id <= w_err_id_nx;
      r_busy   <= w_busy_nx;
      r_frst   <= w_frst_nx;
      r_qin    <= w_qin_nx;
    end
  end

  assign gnt        = r_gnt;
  assign done       = r_done;
  assign err        = r_err;
  assign err_id     = r_err_id;
  assign clr_busy   = r_busy;
  assign flop_reset = r_frst;
  assign flop_qin   = r_qin;

endmodule

// File: tb/tb_flop_share_ctrl.sv
// Bench for flop_share_ctrl: a model of the shared register, a schedule-based
// expectation model checked every cycle, and directed scenarios with literals.
module tb_flop_share_ctrl;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int CLR = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic           clr_req;
  logic [N-1:0]   gnt;
  logic           done, err, clr_busy, flop_reset;
  logic [1:0]     err_id;
  logic [W-1:0]   flop_qin, flop_qout;

  logic [W-1:0]   q = '0;
  logic           corrupt = 1'b0;
  logic           cmp_en = 1'b0;
  int             n_chk = 0;
  int             n_err = 0;

  flop_share_ctrl #(.N_REQ(N), .WIDTH(W), .CLR_CYCLES(CLR)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .gnt(gnt),
    .done(done), .err(err), .err_id(err_id), .clr_req(clr_req),
    .clr_busy(clr_busy), .flop_reset(flop_reset), .flop_qin(flop_qin),
    .flop_qout(flop_qout)
  );

  always #5 clk = ~clk;

  // Shared register: synchronous active-high reset; bench can force its output to 0.
  always @(posedge clk) q <= flop_reset ? '0 : flop_qin;
  assign flop_qout = corrupt ? '0 : q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_slice(input int i, input logic [W-1:0] v);
    wdata[i*W +: W] = v;
  endtask

  // ---------------- expectation model ----------------
  // Outputs after edge e are derived from the edges at which events were
  // scheduled: grant at g, done/readback at g+2, clear high while e < clr_end.
  int         m_cyc = 0, gnt_edge = -1, done_edge = -1, chk_edge = -1;
  int         clr_end = 0, free_at = 0, m_ptr = 0, chk_id = 0, m_win;
  logic [N-1:0] gnt_val = '0;
  logic [W-1:0] m_held = '0;
  logic       m_err = 1'b0;
  logic [1:0] m_err_id = '0;
  logic [1:0] m_idx;
  logic [N-1:0] x_gnt = '0;
  logic       x_done = 1'b0, x_frst = 1'b1, x_err = 1'b0;
  logic [1:0] x_err_id = '0;
  logic [W-1:0] x_qin = '0;

  initial forever begin
    @(posedge clk);
    m_cyc++;
    if (!reset) begin
      gnt_edge = -1; done_edge = -1; chk_edge = -1;
      m_err = 1'b0; m_err_id = '0; m_ptr = 0; m_held = '0;
      clr_end = m_cyc + CLR;
      free_at = m_cyc + CLR + 1;
    end else begin
      if (chk_edge == m_cyc && !m_err && flop_qout !== m_held) begin
        m_err = 1'b1;
        m_err_id = 2'(chk_id);
      end
      if (m_cyc >= free_at) begin
        if (clr_req) begin
          clr_end = m_cyc + CLR;
          m_held  = '0;
          free_at = m_cyc + CLR + 1;
        end else if (req != '0) begin
          m_win = -1;
          for (int k = 0; k < N; k++) begin
            m_idx = 2'((m_ptr + k) % N);
            if (m_win < 0 && req[m_idx]) m_win = (m_ptr + k) % N;
          end
          gnt_val   = N'(1) << m_win;
          gnt_edge  = m_cyc;
          done_edge = m_cyc + 2;
          chk_edge  = m_cyc + 2;
          chk_id    = m_win;
          m_held    = W'(wdata >> (m_win * W));
          m_ptr     = (m_win + 1) % N;
          free_at   = m_cyc + 3;
        end
      end
    end
    x_gnt    = (m_cyc == gnt_edge) ? gnt_val : '0;
    x_done   = (m_cyc == done_edge);
    x_frst   = (m_cyc < clr_end);
    x_qin    = x_frst ? '0 : m_held;
    x_err    = m_err;
    x_err_id = m_err_id;
  end

  // Every-cycle compare; while reset is low the reset values apply immediately.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("cyc_gnt",      gnt,        reset ? x_gnt    : '0);
      chk("cyc_done",     done,       reset ? x_done   : 1'b0);
      chk("cyc_err",      err,        reset ? x_err    : 1'b0);
      chk("cyc_err_id",   err_id,     reset ? x_err_id : 2'd0);
      chk("cyc_clr_busy", clr_busy,   reset ? x_frst   : 1'b1);
      chk("cyc_flop_rst", flop_reset, reset ? x_frst   : 1'b1);
      chk("cyc_flop_qin", flop_qin,   reset ? x_qin    : '0);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_gnt();
    int n = 0;
    while (gnt == '0 && n < 12) begin tick(); n++; end
    chk("gnt_seen", {31'd0, gnt != '0}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 12) begin tick(); n++; end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset();
    int n = 0;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    while (flop_reset && n < 20) begin tick(); n++; end
    tick();
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    int n, last;
    logic ds;
    req = '0; wdata = '0; clr_req = 1'b0; corrupt = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    repeat (3) tick();

    // Power-up clear: flop_reset high exactly CLR cycles after release.
    reset = 1'b1;
    #1;
    n = 0;
    while (flop_reset && n < 20) begin n++; tick(); end
    chk("pwr_clr_cycles", n, 3);
    chk("pwr_clr_busy", {31'd0, clr_busy}, 0);
    chk("pwr_qin", flop_qin, 8'h00);
    chk("pwr_qout", flop_qout, 8'h00);
    chk("pwr_gnt", gnt, 4'b0000);

    // Single write from requester 2.
    tick();
    req = 4'b0100; set_slice(2, 8'hA5);
    tick();
    chk("w2_gnt", gnt, 4'b0100);
    req = '0;
    tick();
    chk("w2_gnt_drop", gnt, 4'b0000);
    chk("w2_qout", flop_qout, 8'hA5);
    chk("w2_done_early", {31'd0, done}, 0);
    tick();
    chk("w2_done", {31'd0, done}, 1);
    chk("w2_err", {31'd0, err}, 0);
    tick();
    chk("w2_done_pulse", {31'd0, done}, 0);
    repeat (10) tick();
    chk("w2_hold", flop_qout, 8'hA5);

    // Round robin with all requesters held, from a fresh pointer.
    do_reset();
    for (int i = 0; i < N; i++) set_slice(i, 8'h10 + 8'(i));
    req = 4'b1111;
    last = 0;
    for (int g = 0; g < 5; g++) begin
      wait_gnt();
      chk("rr_gnt", gnt, 4'b0001 << (g % 4));
      if (g > 0) chk("rr_spacing", m_cyc - last, 3);
      last = m_cyc;
      if (g == 4) req = '0;
      tick();
      chk("rr_qout", flop_qout, 8'h10 + 8'(g % 4));
    end

    // Clear has priority over a simultaneous request.
    repeat (4) tick();
    clr_req = 1'b1; req = 4'b0010; set_slice(1, 8'h5A);
    tick();
    clr_req = 1'b0;
    n = 0;
    while (flop_reset && n < 20) begin n++; tick(); end
    chk("clr_cycles", n, 3);
    chk("clr_qout", flop_qout, 8'h00);
    wait_gnt();
    chk("clr_then_gnt", gnt, 4'b0010);
    req = '0;
    tick();
    chk("clr_then_qout", flop_qout, 8'h5A);
    wait_done();

    // Readback mismatch from requester 3, then a good write keeps the flag.
    repeat (2) tick();
    corrupt = 1'b1; req = 4'b1000; set_slice(3, 8'h3C);
    wait_gnt();
    chk("bad_gnt", gnt, 4'b1000);
    req = '0;
    wait_done();
    chk("bad_err", {31'd0, err}, 1);
    chk("bad_err_id", err_id, 3);
    corrupt = 1'b0;
    tick();
    req = 4'b0001; set_slice(0, 8'h77);
    wait_gnt();
    chk("good_gnt", gnt, 4'b0001);
    req = '0;
    wait_done();
    chk("good_err", {31'd0, err}, 1);
    chk("good_err_id", err_id, 3);
    chk("good_qout", flop_qout, 8'h77);

    // Reset pulse during WRITE of 8'hFF aborts the write.
    repeat (2) tick();
    req = 4'b0010; set_slice(1, 8'hFF);
    wait_gnt();
    reset = 1'b0;
    #1;
    chk("abort_gnt", gnt, 4'b0000);
    chk("abort_frst", {31'd0, flop_reset}, 1);
    chk("abort_err", {31'd0, err}, 0);
    req = '0;
    tick();
    reset = 1'b1;
    #1;
    n = 0; ds = 1'b0;
    while (flop_reset && n < 20) begin
      n++;
      if (done || !clr_busy) ds = 1'b1;
      tick();
    end
    chk("abort_clr_cycles", n, 3);
    repeat (3) begin
      if (done) ds = 1'b1;
      tick();
    end
    chk("abort_no_done", {31'd0, ds}, 0);
    chk("abort_qout", flop_qout, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
